// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS control sequencer.
//   - state_t       : 4-bit FSM state, exported on the debug port
//   - OP_* / FUNC_* : instruction opcode and function-field constants
//   - ALU_*, PC_SRC_*, SRCB_*, REG_DST_*, M2R_* : datapath select encodings
//   - instr_class_t : one-hot instruction class from mc_ctrl_decode
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_I_EXEC   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_JAL      = 4'd13,
    S_JR       = 4'd14,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FUNC_JR  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_RTYPE = 2'd2;
  localparam logic [1:0] ALU_ITYPE = 2'd3;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  // Exactly one bit is set for any op/func combination.
  typedef struct packed {
    logic lw;
    logic sw;
    logic r_alu;
    logic jr;
    logic beq;
    logic bne;
    logic i_alu;
    logic j;
    logic jal;
    logic illegal;
  } instr_class_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational instruction classifier.
//   op_i   [5:0] : IR[31:26]
//   func_i [5:0] : IR[5:0], only consulted for R-type (jr detection)
//   cls_o        : one-hot instruction class
//   zext_o       : immediate is zero-extended (andi/ori/xori)
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]   op_i,
  input  logic [5:0]   func_i,
  output instr_class_t cls_o,
  output logic         zext_o
);

  always_comb begin
    cls_o  = '0;
    zext_o = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        if (func_i == FUNC_JR) cls_o.jr = 1'b1;
        else                   cls_o.r_alu = 1'b1;
      end
      OP_LW:  cls_o.lw  = 1'b1;
      OP_SW:  cls_o.sw  = 1'b1;
      OP_BEQ: cls_o.beq = 1'b1;
      OP_BNE: cls_o.bne = 1'b1;
      OP_J:   cls_o.j   = 1'b1;
      OP_JAL: cls_o.jal = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_LUI: cls_o.i_alu = 1'b1;
      OP_ANDI, OP_ORI, OP_XORI: begin
        cls_o.i_alu = 1'b1;
        zext_o      = 1'b1;
      end
      default: cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control sequencer.
//   clk, reset (async, active-high)
//   op, func         : instruction fields from IR
//   zero             : ALU zero flag, used in BRANCH
//   mem_ready        : memory access completes this cycle
//   pc_wr .. pc_src  : datapath write enables and mux selects
//   illegal          : one-cycle pulse on an unsupported instruction
//   state            : current FSM state (debug)
//
// Memory handshake: while the FSM is in FETCH, MEM_RD or MEM_WR it holds its
// strobes (mem_rd / mem_wr, i_or_d) steady; the access completes on the
// rising edge where mem_ready is 1, and only then does the FSM advance. There
// is no separate request valid: the strobes themselves are the request.
//
// Outputs decode combinationally from the state register, so an asserted
// reset forces every strobe and write enable low without waiting for a clock.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_wr,
  output logic       pc_wr_cond,
  output logic       ir_wr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       i_or_d,
  output logic       reg_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic [3:0] state
);

  state_t       state_q, state_d;
  instr_class_t cls;
  logic         zext;

  mc_ctrl_decode u_decode (
    .op_i   (op),
    .func_i (func),
    .cls_o  (cls),
    .zext_o (zext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (cls.lw || cls.sw) state_d = S_MEM_ADDR;
        else if (cls.r_alu)   state_d = S_R_EXEC;
        else if (cls.jr)      state_d = S_JR;
        else if (cls.beq || cls.bne) state_d = S_BRANCH;
        else if (cls.i_alu)   state_d = S_I_EXEC;
        else if (cls.j)       state_d = S_JUMP;
        else if (cls.jal)     state_d = S_JAL;
        else                  state_d = S_ILLEGAL;
      end
      S_MEM_ADDR: state_d = cls.lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_wr      = 1'b0;
    pc_wr_cond = 1'b0;
    ir_wr      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    i_or_d     = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = M2R_ALUOUT;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    ext_op     = 1'b0;
    alu_op     = ALU_ADD;
    pc_src     = PC_SRC_ALU;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = SRCB_FOUR;
        // IR load and PC+4 commit only on the cycle the fetch completes.
        ir_wr     = mem_ready;
        pc_wr     = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_op    = 1'b1;
      end
      S_MEM_RD: begin
        mem_rd = 1'b1;
        i_or_d = 1'b1;
      end
      S_MEM_WB: begin
        reg_wr     = 1'b1;
        mem_to_reg = M2R_MDR;
      end
      S_MEM_WR: begin
        mem_wr = 1'b1;
        i_or_d = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        reg_wr  = 1'b1;
        reg_dst = REG_DST_RD;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ITYPE;
        ext_op    = ~zext;
      end
      S_I_WB: reg_wr = 1'b1;
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = PC_SRC_ALUOUT;
        pc_wr_cond = 1'b1;
        // beq takes on equal operands, bne on unequal.
        pc_wr      = (cls.beq & zero) | (cls.bne & ~zero);
      end
      S_JUMP: begin
        pc_wr  = 1'b1;
        pc_src = PC_SRC_JUMP;
      end
      S_JAL: begin
        pc_wr      = 1'b1;
        pc_src     = PC_SRC_JUMP;
        reg_wr     = 1'b1;
        reg_dst    = REG_DST_RA;
        mem_to_reg = M2R_PC;
      end
      S_JR: begin
        pc_wr  = 1'b1;
        pc_src = PC_SRC_REG;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed bench for mc_ctrl. A table of instruction vectors with
// hand-computed cycle counts and control words, plus hand-written sequences
// for reset, fetch stall, memory wait states and reset mid-instruction.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, func;
  logic       zero, mem_ready;
  logic       pc_wr, pc_wr_cond, ir_wr, mem_rd, mem_wr, i_or_d, reg_wr;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;
  logic       alu_src_a, ext_op, illegal;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .func       (func),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_wr      (pc_wr),
    .pc_wr_cond (pc_wr_cond),
    .ir_wr      (ir_wr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .i_or_d     (i_or_d),
    .reg_wr     (reg_wr),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_op     (ext_op),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .illegal    (illegal),
    .state      (state)
  );

  // ---------------- expected control words ----------------
  typedef struct packed {
    logic       pc_wr;
    logic       pc_wr_cond;
    logic       ir_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       i_or_d;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal;
  } ctl_t;

  //                       pcw   pcc   irw   mrd   mwr   iod   rw    rdst  m2r   sa    sb    ext   aop   psrc  ill
  localparam ctl_t ZERO_X   = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0};
  localparam ctl_t FETCH_X  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd1,1'b0,2'd0,2'd0,1'b0};
  localparam ctl_t FWAIT_X  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd1,1'b0,2'd0,2'd0,1'b0};
  localparam ctl_t DECODE_X = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd3,1'b0,2'd0,2'd0,1'b0};
  localparam ctl_t REXEC_X  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd0,1'b0,2'd2,2'd0,1'b0};
  localparam ctl_t RWB_X    = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd1,2'd0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0};
  localparam ctl_t MADDR_X  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd2,1'b1,2'd0,2'd0,1'b0};
  localparam ctl_t MEMRD_X  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0};
  localparam ctl_t MEMWB_X  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd1,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0};
  localparam ctl_t MEMWR_X  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,2'd0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0};
  localparam ctl_t BR_T_X   = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd0,1'b0,2'd1,2'd1,1'b0};
  localparam ctl_t BR_N_X   = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd0,1'b0,2'd1,2'd1,1'b0};
  localparam ctl_t IEXZ_X   = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd2,1'b0,2'd3,2'd0,1'b0};
  localparam ctl_t IEXS_X   = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd2,1'b1,2'd3,2'd0,1'b0};
  localparam ctl_t IWB_X    = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0};
  localparam ctl_t JUMP_X   = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd0,1'b0,2'd0,2'd2,1'b0};
  localparam ctl_t JAL_X    = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd2,1'b0,2'd0,1'b0,2'd0,2'd2,1'b0};
  localparam ctl_t JR_X     = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd0,1'b0,2'd0,2'd3,1'b0};
  localparam ctl_t ILL_X    = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b1};

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    int         cycles;
    state_t     exec_st;
    ctl_t       exec_x;
    state_t     last_st;
    ctl_t       last_x;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];

  // ---------------- scoreboard counters ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ctl_t get_ctl();
    ctl_t c;
    c.pc_wr      = pc_wr;
    c.pc_wr_cond = pc_wr_cond;
    c.ir_wr      = ir_wr;
    c.mem_rd     = mem_rd;
    c.mem_wr     = mem_wr;
    c.i_or_d     = i_or_d;
    c.reg_wr     = reg_wr;
    c.reg_dst    = reg_dst;
    c.mem_to_reg = mem_to_reg;
    c.alu_src_a  = alu_src_a;
    c.alu_src_b  = alu_src_b;
    c.ext_op     = ext_op;
    c.alu_op     = alu_op;
    c.pc_src     = pc_src;
    c.illegal    = illegal;
    return c;
  endfunction

  // Watches for any register write while an aborted instruction is in flight.
  logic watch_rw = 1'b0;
  logic saw_rw   = 1'b0;
  always @(posedge reg_wr) if (watch_rw) saw_rw = 1'b1;

  // ---------------- driver tasks ----------------
  // Both tasks start in the low phase of a FETCH cycle and return in the low
  // phase of the next FETCH cycle. Inputs change just after a falling edge.
  task automatic run_vec(input vec_t v);
    int     cyc;
    ctl_t   last;
    state_t last_st;
    op = v.op; func = v.func; zero = v.zero;
    cyc = 0; last = ZERO_X; last_st = S_IDLE;
    while (1) begin
      mem_ready = 1'b1;
      #1;
      if ((cyc > 0 && state == S_FETCH) || cyc >= 20) break;
      if (cyc == 0) chk({v.name, " fetch"}, 32'(get_ctl()), 32'(FETCH_X));
      if (cyc == 1) chk({v.name, " decode"}, 32'(get_ctl()), 32'(DECODE_X));
      if (cyc == 2) begin
        chk({v.name, " exec_state"}, 32'(state), 32'(v.exec_st));
        chk({v.name, " exec_ctl"}, 32'(get_ctl()), 32'(v.exec_x));
      end
      last = get_ctl();
      last_st = state_t'(state);
      cyc++;
      @(negedge clk);
    end
    chk({v.name, " cycles"}, 32'(cyc), 32'(v.cycles));
    chk({v.name, " last_state"}, 32'(last_st), 32'(v.last_st));
    chk({v.name, " last_ctl"}, 32'(last), 32'(v.last_x));
  endtask

  // Memory instruction with nwait cycles of mem_ready=0 starting at cycle 3.
  task automatic run_wait(input string name, input logic [5:0] o, input int nwait,
                          input int exp_cyc, input state_t wait_st, input ctl_t wait_x,
                          input ctl_t last_x);
    int   cyc;
    ctl_t last;
    op = o; func = 6'd0; zero = 1'b0;
    cyc = 0; last = ZERO_X;
    while (1) begin
      mem_ready = !(cyc >= 3 && cyc < 3 + nwait);
      #1;
      if ((cyc > 0 && state == S_FETCH) || cyc >= 20) break;
      if (!mem_ready) begin
        chk({name, " wait_state"}, 32'(state), 32'(wait_st));
        chk({name, " wait_ctl"}, 32'(get_ctl()), 32'(wait_x));
      end
      last = get_ctl();
      cyc++;
      @(negedge clk);
    end
    chk({name, " cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({name, " last_ctl"}, 32'(last), 32'(last_x));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0]  = '{"add",   6'b000000, 6'b100000, 1'b0, 4, S_R_EXEC,   REXEC_X, S_R_WB,   RWB_X};
    vecs[1]  = '{"sub",   6'b000000, 6'b100010, 1'b0, 4, S_R_EXEC,   REXEC_X, S_R_WB,   RWB_X};
    vecs[2]  = '{"lw",    6'b100011, 6'b000000, 1'b0, 5, S_MEM_ADDR, MADDR_X, S_MEM_WB, MEMWB_X};
    vecs[3]  = '{"sw",    6'b101011, 6'b000000, 1'b0, 4, S_MEM_ADDR, MADDR_X, S_MEM_WR, MEMWR_X};
    vecs[4]  = '{"beq_z1",6'b000100, 6'b000000, 1'b1, 3, S_BRANCH,   BR_T_X,  S_BRANCH, BR_T_X};
    vecs[5]  = '{"bne_z1",6'b000101, 6'b000000, 1'b1, 3, S_BRANCH,   BR_N_X,  S_BRANCH, BR_N_X};
    vecs[6]  = '{"beq_z0",6'b000100, 6'b000000, 1'b0, 3, S_BRANCH,   BR_N_X,  S_BRANCH, BR_N_X};
    vecs[7]  = '{"bne_z0",6'b000101, 6'b000000, 1'b0, 3, S_BRANCH,   BR_T_X,  S_BRANCH, BR_T_X};
    vecs[8]  = '{"ori",   6'b001101, 6'b000000, 1'b0, 4, S_I_EXEC,   IEXZ_X,  S_I_WB,   IWB_X};
    vecs[9]  = '{"addi",  6'b001000, 6'b000000, 1'b0, 4, S_I_EXEC,   IEXS_X,  S_I_WB,   IWB_X};
    vecs[10] = '{"andi",  6'b001100, 6'b000000, 1'b0, 4, S_I_EXEC,   IEXZ_X,  S_I_WB,   IWB_X};
    vecs[11] = '{"lui",   6'b001111, 6'b000000, 1'b0, 4, S_I_EXEC,   IEXS_X,  S_I_WB,   IWB_X};
    vecs[12] = '{"j",     6'b000010, 6'b000000, 1'b0, 3, S_JUMP,     JUMP_X,  S_JUMP,   JUMP_X};
    vecs[13] = '{"jal",   6'b000011, 6'b000000, 1'b0, 3, S_JAL,      JAL_X,   S_JAL,    JAL_X};
    vecs[14] = '{"jr",    6'b000000, 6'b001000, 1'b0, 3, S_JR,       JR_X,    S_JR,     JR_X};
    vecs[15] = '{"ill_3f",6'b111111, 6'b000000, 1'b0, 3, S_ILLEGAL,  ILL_X,   S_ILLEGAL,ILL_X};
    vecs[16] = '{"ill_01",6'b000001, 6'b000000, 1'b0, 3, S_ILLEGAL,  ILL_X,   S_ILLEGAL,ILL_X};

    // Reset: everything low while held, IDLE until the first edge after release.
    reset = 1'b1; mem_ready = 1'b1; op = 6'd0; func = 6'd0; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset state", 32'(state), 32'(S_IDLE));
    chk("reset ctl", 32'(get_ctl()), 32'(ZERO_X));
    reset = 1'b0;
    #1;
    chk("post_release idle", 32'(state), 32'(S_IDLE));
    @(negedge clk); #1;
    chk("first fetch state", 32'(state), 32'(S_FETCH));
    chk("first fetch ctl", 32'(get_ctl()), 32'(FETCH_X));

    // Fetch stall: strobes hold, no IR/PC write, state stays put.
    mem_ready = 1'b0;
    #1;
    chk("fetch wait ctl", 32'(get_ctl()), 32'(FWAIT_X));
    @(negedge clk); #1;
    chk("fetch wait state", 32'(state), 32'(S_FETCH));
    chk("fetch wait ctl2", 32'(get_ctl()), 32'(FWAIT_X));

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Memory wait states in MEM_RD / MEM_WR.
    run_wait("lw_wait2", 6'b100011, 2, 7, S_MEM_RD, MEMRD_X, MEMWB_X);
    run_wait("sw_wait1", 6'b101011, 1, 5, S_MEM_WR, MEMWR_X, MEMWR_X);

    // Illegal opcode, then reset during R_EXEC of an add.
    run_vec(vecs[15]);
    op = 6'b000000; func = 6'b100000; zero = 1'b0; mem_ready = 1'b1;
    saw_rw = 1'b0; watch_rw = 1'b1;
    #1;
    chk("abort fetch", 32'(state), 32'(S_FETCH));
    repeat (2) @(negedge clk);
    #1;
    chk("abort r_exec", 32'(state), 32'(S_R_EXEC));
    #1 reset = 1'b1;
    #1;
    chk("async reset state", 32'(state), 32'(S_IDLE));
    chk("async reset ctl", 32'(get_ctl()), 32'(ZERO_X));
    @(negedge clk); #1;
    chk("held reset state", 32'(state), 32'(S_IDLE));
    reset = 1'b0;
    @(negedge clk); #1;
    chk("after abort fetch", 32'(state), 32'(S_FETCH));
    watch_rw = 1'b0;
    chk("aborted add reg_wr", 32'(saw_rw), 32'd0);

    // Normal operation resumes after the abort.
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the MIPS datapath. It steps each instruction through fetch, decode, execute, memory and write-back states, and drives the datapath mux selects and write enables. It supplies the 2-bit `alu_op` class that the ALU control decoder combines with `op`/`func` to form `ALUctr`. It stalls on a memory ready handshake and flags unsupported opcodes.

## Interface
- No parameters; all encodings are fixed constants in `mc_ctrl_pkg`.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `op` input 6: `IR[31:26]`, valid from DECODE onward.
- `func` input 6: `IR[5:0]`.
- `zero` input 1: ALU zero flag, sampled in BRANCH.
- `mem_ready` input 1: memory completes the current access this cycle.
- `pc_wr` output 1: unconditional PC write.
- `pc_wr_cond` output 1: PC write if the branch condition holds; qualified internally and folded into `pc_wr`.
- `ir_wr` output 1: instruction register load.
- `mem_rd`, `mem_wr` output 1 each: memory strobes.
- `i_or_d` output 1: address select, 0 = PC, 1 = ALUOut.
- `reg_wr` output 1: register-file write.
- `reg_dst` output 2: write register select, 0 = rt, 1 = rd, 2 = $31.
- `mem_to_reg` output 2: write data select, 0 = ALUOut, 1 = MDR, 2 = PC.
- `alu_src_a` output 1: 0 = PC, 1 = A.
- `alu_src_b` output 2: 0 = B, 1 = const 4, 2 = sign/zero-extended imm, 3 = imm<<2.
- `ext_op` output 1: 1 = sign-extend, 0 = zero-extend (andi/ori/xori).
- `alu_op` output 2: 0 = ADD, 1 = SUB, 2 = R-type (decode `func`), 3 = I-type (decode `op`).
- `pc_src` output 2: 0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = A (jr).
- `illegal` output 1: one-cycle pulse on an unsupported instruction.
- `state` output 4: current state, for debug.

## Operation
- Supported instructions: R-type (op 000000, including jr func 001000), lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, addiu 001001, slti 001010, andi 001100, ori 001101, xori 001110, lui 001111, j 000010, jal 000011.
- IDLE: all outputs 0. Entered on reset; moves to FETCH on the first clock edge after `reset` falls.
- FETCH: `mem_rd`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=ADD, `pc_src`=0.
  - `ir_wr` and `pc_wr` assert only when `mem_ready`=1. Same-cycle (Mealy) qualification.
  - Stays in FETCH while `mem_ready`=0; moves to DECODE when `mem_ready`=1.
- DECODE: computes the branch target (`alu_src_a`=0, `alu_src_b`=3, ADD). Next state:
  - lw/sw → MEM_ADDR
  - R-type other than jr → R_EXEC
  - jr → JR
  - beq/bne → BRANCH
  - I-type ALU → I_EXEC
  - j → JUMP
  - jal → JAL
  - anything else → ILLEGAL
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=2, `ext_op`=1, ADD. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_rd`=1, `i_or_d`=1. Holds until `mem_ready`, then goes to MEM_WB.
- MEM_WB: `reg_wr`=1, `reg_dst`=0, `mem_to_reg`=1. Next state FETCH.
- MEM_WR: `mem_wr`=1, `i_or_d`=1. Holds until `mem_ready`, then goes to FETCH.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=2. Next state R_WB.
- R_WB: `reg_wr`=1, `reg_dst`=1, `mem_to_reg`=0. Next state FETCH.
- I_EXEC: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=3. `ext_op`=0 for andi/ori/xori, else 1. Next state I_WB.
- I_WB: `reg_wr`=1, `reg_dst`=0, `mem_to_reg`=0. Next state FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, SUB, `pc_src`=1, `pc_wr_cond`=1. Next state FETCH.
  - `pc_wr` = `zero` for beq, `!zero` for bne.
- JUMP: `pc_wr`=1, `pc_src`=2. Next state FETCH.
- JAL: `pc_wr`=1, `pc_src`=2, `reg_wr`=1, `reg_dst`=2, `mem_to_reg`=2. Next state FETCH. The PC value written to $31 is already PC+4.
- JR: `pc_wr`=1, `pc_src`=3. Next state FETCH.
- ILLEGAL: `illegal`=1 for exactly one cycle, no writes. Next state FETCH; PC is already advanced.
- Every output not listed for a state is 0.

## Timing
- Cycles per instruction with no wait states:
  - beq, bne, j, jal, jr, illegal: 3
  - R-type, I-type ALU, sw: 4
  - lw: 5
- Each wait cycle (`mem_ready`=0) adds one cycle in FETCH, MEM_RD or MEM_WR. Strobes stay asserted and stable while waiting.
- Reset asserted mid-instruction: `state` goes to IDLE and all outputs go to 0 immediately (asynchronous). No partial write completes after reset assertion.
- `op`/`func` changing outside DECODE and the execute states has no effect.

## Structure
- `mc_ctrl_pkg` holds:
  - the state enum (4-bit)
  - opcode and func constants
  - `alu_op`, `pc_src`, `alu_src_b`, `reg_dst` and `mem_to_reg` encodings
- Sub-module `mc_ctrl_decode` is combinational. It classifies `op`/`func` into one-hot instruction classes used for the next-state and `ext_op`/branch decisions.
- Top level `mc_ctrl` contains the state register and the output decode.

## Test plan
- Reset, then release with `mem_ready`=1 held high. Expect IDLE → FETCH, `mem_rd`=1, `ir_wr`=`pc_wr`=1 in the first FETCH cycle, all outputs 0 during reset.
- lw (op 100011) with `mem_ready` low for 2 cycles in MEM_RD. Expect 7 cycles total, `mem_rd`=1 and `i_or_d`=1 stable throughout the wait, `reg_wr`=1 with `mem_to_reg`=1 in the last cycle.
- beq with `zero`=1, then bne with `zero`=1. Expect `pc_wr`=1 in BRANCH for beq, `pc_wr`=0 for bne, and 3 cycles each.
- ori (001101), then addi (001000). Expect `ext_op`=0 and 1 respectively, `alu_op`=3, write-back with `reg_dst`=0.
- jal, then R-type jr (func 001000). For jal expect `reg_dst`=2, `mem_to_reg`=2, `pc_src`=2; for jr expect `pc_src`=3 and 3 cycles.
- Opcode 111111, then `reset` asserted during R_EXEC of an add. Expect a single-cycle `illegal` pulse followed by FETCH; the reset forces IDLE asynchronously and no `reg_wr` is ever issued for the add.
